to_upper_arbiter: RTL and testbench

Shares one combinational lowercase-to-uppercase converter between two byte-stream requesters. Each requester sends a string as a valid/ready byte stream terminated by a `last` flag. The arbiter grants one whole string at a time using round-robin priority. It converts each byte and presents the result on a single registered output stream tagged with the requester ID. Per-requester saturating counters record how many letters were converted. It sits between the character sources and any downstream ASCII consumer.

---
 rtl/to_upper_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_to_upper_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/to_upper_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : to_upper_arbiter
//  Description : Shares one lowercase-to-uppercase byte converter between two
//                valid/ready string requesters. Whole strings (terminated by
//                a `last` byte) are granted round-robin. The converted bytes
//                leave on one registered output stream tagged with the
//                requester ID. Per-requester saturating counters track how
//                many letters were converted.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CNT_W       width of each converted-letter counter (default 16)
//  Ports
//    clk         sole clock, rising edge
//    rst_n       asynchronous active-low reset
//    reqN_valid  requester N byte available (N = 0, 1)
//    reqN_data   requester N byte
//    reqN_last   requester N byte ends its string
//    reqN_ready  requester N byte accepted this cycle when valid is high
//    out_valid   output byte available
//    out_data    converted byte
//    out_id      requester that supplied out_data
//    out_last    out_data ends its string
//    out_ready   downstream accepts the output byte
//    cnt0/cnt1   lowercase letters converted, per requester (saturating)
//    busy        arbiter is holding a grant (state not IDLE)
// ============================================================================
module to_upper_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_id,
  output logic             out_last,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [7:0]       c_lower_a  = 8'h61;
  localparam logic [7:0]       c_lower_z  = 8'h7A;
  localparam logic [7:0]       c_case_off = 8'h20;
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT0 = 2'd1,
    S_GNT1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Requester that was served last; the other one wins a tie in IDLE.
  logic   r_ptr;
  logic   w_ptr_nxt;

  // --------------------------------------------------------------------------
  // Conversion helpers
  // --------------------------------------------------------------------------
  function automatic logic is_lower(input logic [7:0] b);
    return (b >= c_lower_a) && (b <= c_lower_z);
  endfunction

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    return is_lower(b) ? (b - c_case_off) : b;
  endfunction

  // --------------------------------------------------------------------------
  // Requester-side vectors, indexed by requester ID
  // --------------------------------------------------------------------------
  logic [1:0] w_valid;
  logic [1:0] w_last;
  logic [1:0] w_ready;
  logic [1:0] w_accept;
  logic [1:0] w_lower;
  logic [7:0] w_data [2];

  assign w_valid   = {req1_valid, req0_valid};
  assign w_last    = {req1_last,  req0_last};
  assign w_data[0] = req0_data;
  assign w_data[1] = req1_data;
  assign w_lower   = {is_lower(req1_data), is_lower(req0_data)};

  // The output register can take a new byte when it is empty or is being
  // drained this very cycle.
  logic w_out_free;
  assign w_out_free = !out_valid || out_ready;

  // Only the granted requester ever sees ready; IDLE grants nothing.
  always_comb begin
    w_ready = 2'b00;
    case (r_state)
      S_GNT0:  w_ready[0] = w_out_free;
      S_GNT1:  w_ready[1] = w_out_free;
      default: w_ready    = 2'b00;
    endcase
  end

  assign w_accept   = w_valid & w_ready;
  assign req0_ready = w_ready[0];
  assign req1_ready = w_ready[1];

  // At most one bit of w_accept can be set, so the granted requester picks
  // the byte that goes into the output register.
  logic       w_any_accept;
  logic       w_sel;
  logic [7:0] w_sel_data;
  logic       w_sel_last;

  assign w_any_accept = |w_accept;
  assign w_sel        = (r_state == S_GNT1);
  assign w_sel_data   = w_sel ? w_data[1] : w_data[0];
  assign w_sel_last   = w_sel ? w_last[1] : w_last[0];

  // --------------------------------------------------------------------------
  // Arbitration state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_valid[0] && w_valid[1]) begin
          // Tie: the requester not served last goes first.
          w_state_nxt = r_ptr ? S_GNT0 : S_GNT1;
        end else if (w_valid[0]) begin
          w_state_nxt = S_GNT0;
        end else if (w_valid[1]) begin
          w_state_nxt = S_GNT1;
        end
      end
      S_GNT0: begin
        // A grant is held until the last byte is taken, even if valid
        // drops in the middle of the string.
        if (w_accept[0] && w_last[0]) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = 1'b0;
        end
      end
      S_GNT1: begin
        if (w_accept[1] && w_last[1]) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy = (r_state != S_IDLE);

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  // A new accept takes priority over the drain, so a simultaneous output
  // handshake and accept reloads the register and keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_id    <= 1'b0;
      out_last  <= 1'b0;
    end else if (w_any_accept) begin
      out_valid <= 1'b1;
      out_data  <= to_upper(w_sel_data);
      out_id    <= w_sel;
      out_last  <= w_sel_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Per-requester saturating letter counters
  // --------------------------------------------------------------------------
  logic [1:0][CNT_W-1:0] w_cnt;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (w_accept[gi] && w_lower[gi] && (r_cnt != c_cnt_max)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_cnt[gi] = r_cnt;
    end
  endgenerate

  assign cnt0 = w_cnt[0];
  assign cnt1 = w_cnt[1];

endmodule
`default_nettype wire

// File: tb/tb_to_upper_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_to_upper_arbiter
//  Description : Self-checking bench for to_upper_arbiter. Runs a table of
//                directed per-cycle vectors (conversion, boundary bytes, tie
//                and fairness), then hand-written sequences for backpressure,
//                counter saturation and asynchronous reset mid-string.
//                The DUT is built with CNT_W = 2 so saturation is reachable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_to_upper_arbiter;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             req0_valid;
  logic [7:0]       req0_data;
  logic             req0_last;
  logic             req0_ready;
  logic             req1_valid;
  logic [7:0]       req1_data;
  logic             req1_last;
  logic             req1_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_id;
  logic             out_last;
  logic             out_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic             busy;

  to_upper_arbiter #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    out_ready = 1'b1;
    rst_n     = 1'b0;
    step();
    rst_n     = 1'b1;
  endtask

  // Per-cycle vector: inputs, expected readies before the edge, expected
  // registered outputs after the edge.
  typedef struct {
    logic             v0;
    logic [7:0]       d0;
    logic             l0;
    logic             v1;
    logic [7:0]       d1;
    logic             l1;
    logic             ordy;
    logic             e_r0;
    logic             e_r1;
    logic             e_ov;
    logic [7:0]       e_od;
    logic             e_id;
    logic             e_ol;
    logic [CNT_W-1:0] e_c0;
    logic [CNT_W-1:0] e_c1;
    logic             e_busy;
  } vec_t;

  function automatic vec_t mk(
    input logic v0, input logic [7:0] d0, input logic l0,
    input logic v1, input logic [7:0] d1, input logic l1,
    input logic ordy, input logic r0, input logic r1,
    input logic ov, input logic [7:0] od, input logic id, input logic ol,
    input logic [CNT_W-1:0] c0, input logic [CNT_W-1:0] c1, input logic bz);
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.l0 = l0;
    v.v1 = v1; v.d1 = d1; v.l1 = l1;
    v.ordy = ordy; v.e_r0 = r0; v.e_r1 = r1;
    v.e_ov = ov; v.e_od = od; v.e_id = id; v.e_ol = ol;
    v.e_c0 = c0; v.e_c1 = c1; v.e_busy = bz;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    // ---- basic conversion: req0 "a Z {" -------------------------------------
    tbl.push_back(mk(1,8'h61,0, 0,8'h00,0, 1, 0,0, 0,8'h00,0,0, 0,0,1));
    tbl.push_back(mk(1,8'h61,0, 0,8'h00,0, 1, 1,0, 1,8'h41,0,0, 1,0,1));
    tbl.push_back(mk(1,8'h5A,0, 0,8'h00,0, 1, 1,0, 1,8'h5A,0,0, 1,0,1));
    tbl.push_back(mk(1,8'h7B,1, 0,8'h00,0, 1, 1,0, 1,8'h7B,0,1, 1,0,0));
    tbl.push_back(mk(0,8'h00,0, 0,8'h00,0, 1, 0,0, 0,8'h00,0,0, 1,0,0));
    // ---- boundary characters on req1 -----------------------------------------
    tbl.push_back(mk(0,8'h00,0, 1,8'h60,0, 1, 0,0, 0,8'h00,0,0, 1,0,1));
    tbl.push_back(mk(0,8'h00,0, 1,8'h60,0, 1, 0,1, 1,8'h60,1,0, 1,0,1));
    tbl.push_back(mk(0,8'h00,0, 1,8'h61,0, 1, 0,1, 1,8'h41,1,0, 1,1,1));
    tbl.push_back(mk(0,8'h00,0, 1,8'h7A,0, 1, 0,1, 1,8'h5A,1,0, 1,2,1));
    tbl.push_back(mk(0,8'h00,0, 1,8'h7B,0, 1, 0,1, 1,8'h7B,1,0, 1,2,1));
    tbl.push_back(mk(0,8'h00,0, 1,8'hE1,0, 1, 0,1, 1,8'hE1,1,0, 1,2,1));
    tbl.push_back(mk(0,8'h00,0, 1,8'h00,1, 1, 0,1, 1,8'h00,1,1, 1,2,0));
    tbl.push_back(mk(0,8'h00,0, 0,8'h00,0, 1, 0,0, 0,8'h00,0,0, 1,2,0));
    // ---- tie: req1 was served last, so req0 goes first ----------------------
    tbl.push_back(mk(1,8'h61,0, 1,8'h63,0, 1, 0,0, 0,8'h00,0,0, 1,2,1));
    tbl.push_back(mk(1,8'h61,0, 1,8'h63,0, 1, 1,0, 1,8'h41,0,0, 2,2,1));
    tbl.push_back(mk(1,8'h62,1, 1,8'h63,0, 1, 1,0, 1,8'h42,0,1, 3,2,0));
    tbl.push_back(mk(0,8'h00,0, 1,8'h63,0, 1, 0,0, 0,8'h00,0,0, 3,2,1));
    tbl.push_back(mk(0,8'h00,0, 1,8'h63,0, 1, 0,1, 1,8'h43,1,0, 3,3,1));
    tbl.push_back(mk(0,8'h00,0, 1,8'h64,1, 1, 0,1, 1,8'h44,1,1, 3,3,0));
    // ---- repeat tie: req1 served last again, req0 wins ----------------------
    tbl.push_back(mk(1,8'h41,1, 1,8'h30,1, 1, 0,0, 0,8'h00,0,0, 3,3,1));
    tbl.push_back(mk(1,8'h41,1, 1,8'h30,1, 1, 1,0, 1,8'h41,0,1, 3,3,0));
    tbl.push_back(mk(0,8'h00,0, 1,8'h30,1, 1, 0,0, 0,8'h00,0,0, 3,3,1));
    tbl.push_back(mk(0,8'h00,0, 1,8'h30,1, 1, 0,1, 1,8'h30,1,1, 3,3,0));
    tbl.push_back(mk(0,8'h00,0, 0,8'h00,0, 1, 0,0, 0,8'h00,0,0, 3,3,0));

    // ---- reset state -------------------------------------------------------
    idle_inputs();
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #12;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data",  out_data,  0);
    chk("reset out_id",    out_id,    0);
    chk("reset out_last",  out_last,  0);
    chk("reset cnt0",      cnt0,      0);
    chk("reset cnt1",      cnt1,      0);
    chk("reset busy",      busy,      0);
    chk("reset req0_ready", req0_ready, 0);
    chk("reset req1_ready", req1_ready, 0);
    step();
    rst_n = 1'b1;

    // ---- table-driven vectors ----------------------------------------------
    for (int i = 0; i < tbl.size(); i++) begin
      req0_valid = tbl[i].v0; req0_data = tbl[i].d0; req0_last = tbl[i].l0;
      req1_valid = tbl[i].v1; req1_data = tbl[i].d1; req1_last = tbl[i].l1;
      out_ready  = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d req0_ready", i), req0_ready, tbl[i].e_r0);
      chk($sformatf("v%0d req1_ready", i), req1_ready, tbl[i].e_r1);
      step();
      chk($sformatf("v%0d out_valid", i), out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) begin
        chk($sformatf("v%0d out_data", i), out_data, tbl[i].e_od);
        chk($sformatf("v%0d out_id", i),   out_id,   tbl[i].e_id);
        chk($sformatf("v%0d out_last", i), out_last, tbl[i].e_ol);
      end
      chk($sformatf("v%0d cnt0", i), cnt0, tbl[i].e_c0);
      chk($sformatf("v%0d cnt1", i), cnt1, tbl[i].e_c1);
      chk($sformatf("v%0d busy", i), busy, tbl[i].e_busy);
    end

    // ---- backpressure: stall 5 cycles after the first byte ------------------
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h61; req0_last = 1'b0;
    step();                                 // grant
    step();                                 // 'a' accepted
    chk("bp first data", out_data, 8'h41);
    req0_data = 8'h62;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp stall%0d req0_ready", k), req0_ready, 0);
      step();
      chk($sformatf("bp stall%0d out_valid", k), out_valid, 1);
      chk($sformatf("bp stall%0d out_data", k),  out_data,  8'h41);
      chk($sformatf("bp stall%0d cnt0", k),      cnt0,      1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release req0_ready", req0_ready, 1);
    step();
    chk("bp byte2", out_data, 8'h42);
    req0_data = 8'h63;
    step();
    chk("bp byte3", out_data, 8'h43);
    req0_data = 8'h64; req0_last = 1'b1;
    step();
    chk("bp byte4", out_data, 8'h44);
    chk("bp byte4 last", out_last, 1);
    chk("bp end busy", busy, 0);
    req0_valid = 1'b0; req0_last = 1'b0;
    step();
    chk("bp drained", out_valid, 0);

    // ---- saturation: five letters with a 2-bit counter ----------------------
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h61; req0_last = 1'b0;
    step();                                 // grant
    for (int k = 0; k < 5; k++) begin
      req0_data = 8'h61 + 8'(k);
      req0_last = (k == 4);
      step();
      chk($sformatf("sat cnt0 #%0d", k), cnt0, (k < 3) ? k + 1 : 3);
      chk($sformatf("sat data #%0d", k), out_data, 8'h41 + 8'(k));
    end
    idle_inputs();
    step();

    // ---- asynchronous reset mid-string -------------------------------------
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h61; req0_last = 1'b0;
    step();                                 // grant
    step();                                 // byte 1
    req0_data = 8'h62;
    step();                                 // byte 2
    chk("mid pre-reset cnt0", cnt0, 2);
    #1;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("mid reset out_valid", out_valid, 0);
    chk("mid reset out_data",  out_data,  0);
    chk("mid reset out_id",    out_id,    0);
    chk("mid reset out_last",  out_last,  0);
    chk("mid reset cnt0",      cnt0,      0);
    chk("mid reset busy",      busy,      0);
    chk("mid reset req0_ready", req0_ready, 0);
    step();
    rst_n = 1'b1;
    req1_valid = 1'b1; req1_data = 8'h6A; req1_last = 1'b1;
    #1;
    chk("post reset req1_ready idle", req1_ready, 0);
    step();
    chk("post reset busy", busy, 1);
    chk("post reset req1_ready", req1_ready, 1);
    step();
    chk("post reset out_valid", out_valid, 1);
    chk("post reset out_data",  out_data,  8'h4A);
    chk("post reset out_id",    out_id,    1);
    chk("post reset out_last",  out_last,  1);
    chk("post reset cnt1",      cnt1,      1);
    chk("post reset cnt0",      cnt0,      0);
    chk("post reset idle",      busy,      0);
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
